// File: rtl/regfile_write_queue_pkg.sv
// regfile_wq_pkg: shared widths and queue entry type for the register-file write queue.
package regfile_wq_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 64;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;
    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wq_entry_t;
endpackage

// File: rtl/regfile_write_queue_if.sv
// regfile_write_queue_if: producer handshakes, commit port and hazard lookup of the write queue.
interface regfile_write_queue_if #(parameter int DEPTH = 4);
    import regfile_wq_pkg::*;
    logic                       ld_valid, ld_ready;
    logic [ADDR_W-1:0]          ld_rd;
    logic [DATA_W-1:0]          ld_data;
    logic                       alu_valid, alu_ready;
    logic [ADDR_W-1:0]          alu_rd;
    logic [DATA_W-1:0]          alu_data;
    logic                       RegWrite;
    logic [ADDR_W-1:0]          WriteRegister;
    logic [DATA_W-1:0]          WriteData;
    logic [ADDR_W-1:0]          rd_addr1, rd_addr2;
    logic                       hazard1, hazard2;
    logic [$clog2(DEPTH):0]     occupancy;
    modport master (
        output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, rd_addr1, rd_addr2,
        input  ld_ready, alu_ready, RegWrite, WriteRegister, WriteData, hazard1, hazard2, occupancy
    );
    modport slave (
        input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, rd_addr1, rd_addr2,
        output ld_ready, alu_ready, RegWrite, WriteRegister, WriteData, hazard1, hazard2, occupancy
    );
endinterface

// File: rtl/regfile_write_queue_addr_match.sv
// wq_addr_match: flags any valid queued entry whose destination equals one read address.
module wq_addr_match
    import regfile_wq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [ADDR_W-1:0] rd [DEPTH],
    input  logic [DEPTH-1:0]  vld,
    input  logic [ADDR_W-1:0] addr,
    output logic              hit
);
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) hit = hit | (vld[i] && rd[i] == addr);
        hit = hit && addr != ZERO_REG;
    end
endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write queue feeding the register file's single write port.
module regfile_write_queue
    import regfile_wq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic                    clk,
    input logic                    reset,
    regfile_write_queue_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    wq_entry_t          ent_q [DEPTH];
    wq_entry_t          ent_d [DEPTH];
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d, alu_slot;
    logic [OW-1:0]      occ_q, occ_d, free;
    logic               ld_push, alu_push, pop;
    logic [ADDR_W-1:0]  rds [DEPTH];
    // Readiness looks only at start-of-cycle occupancy; the same-edge pop is not credited.
    assign free          = OW'(DEPTH) - occ_q;
    assign bus.ld_ready  = free >= OW'(1);
    assign bus.alu_ready = bus.ld_valid ? free >= OW'(2) : free >= OW'(1);
    assign ld_push       = bus.ld_valid && bus.ld_ready && bus.ld_rd != ZERO_REG;
    assign alu_push      = bus.alu_valid && bus.alu_ready && bus.alu_rd != ZERO_REG;
    assign pop           = occ_q != '0;
    assign alu_slot      = tail_q + PW'(ld_push);
    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        if (pop) vld_d[head_q] = 1'b0;
        if (ld_push) begin
            ent_d[tail_q] = '{rd: bus.ld_rd, data: bus.ld_data};
            vld_d[tail_q] = 1'b1;
        end
        if (alu_push) begin
            ent_d[alu_slot] = '{rd: bus.alu_rd, data: bus.alu_data};
            vld_d[alu_slot] = 1'b1;
        end
        head_d = head_q + PW'(pop);
        tail_d = tail_q + PW'(ld_push) + PW'(alu_push);
        occ_d  = occ_q + OW'(ld_push) + OW'(alu_push) - OW'(pop);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            vld_q  <= vld_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end
    // Payload needs no reset: nothing reads an entry unless its valid bit is set.
    always_ff @(posedge clk) ent_q <= ent_d;
    always_comb for (int i = 0; i < DEPTH; i++) rds[i] = ent_q[i].rd;
    assign bus.RegWrite      = pop;
    assign bus.WriteRegister = pop ? ent_q[head_q].rd : '0;
    assign bus.WriteData     = pop ? ent_q[head_q].data : '0;
    assign bus.occupancy     = occ_q;
    wq_addr_match #(.DEPTH(DEPTH)) u_match1 (.rd(rds), .vld(vld_q), .addr(bus.rd_addr1), .hit(bus.hazard1));
    wq_addr_match #(.DEPTH(DEPTH)) u_match2 (.rd(rds), .vld(vld_q), .addr(bus.rd_addr2), .hit(bus.hazard2));
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: directed vector table plus reset and wrap-around sequences.
module tb_regfile_write_queue;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   ncmp = 0;
    int   nerr = 0;
    regfile_write_queue_if #(.DEPTH(4)) bus ();
    regfile_write_queue #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    typedef struct {
        logic        ldv;
        logic [4:0]  ldrd;
        logic [63:0] ldd;
        logic        alv;
        logic [4:0]  alrd;
        logic [63:0] ald;
        logic [4:0]  ra1, ra2;
        logic        e_ldr, e_alr, e_rw;
        logic [4:0]  e_wr;
        logic [63:0] e_wd;
        logic [2:0]  e_occ;
        logic        e_h1, e_h2;
    } vec_t;
    vec_t tv [14];
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic idle();
        bus.ld_valid = 1'b0; bus.ld_rd = 5'd0; bus.ld_data = 64'd0;
        bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 64'd0;
    endtask
    initial begin
        int sent;
        int got;
        logic [4:0]  qr [$];
        logic [63:0] qd [$];
        tv[0]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd3,  64'h5,    5'd3,  5'd0, 1'b1, 1'b1, 1'b1, 5'd3,  64'h5,  3'd1, 1'b1, 1'b0};
        tv[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd3,  5'd0, 1'b1, 1'b1, 1'b0, 5'd0,  64'h0,  3'd0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 5'd1,  64'hAA,   1'b1, 5'd2,  64'hBB,   5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 5'd1,  64'hAA, 3'd2, 1'b1, 1'b1};
        tv[3]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd1,  5'd2, 1'b1, 1'b1, 1'b1, 5'd2,  64'hBB, 3'd1, 1'b0, 1'b1};
        tv[4]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd1,  5'd2, 1'b1, 1'b1, 1'b0, 5'd0,  64'h0,  3'd0, 1'b0, 1'b0};
        tv[5]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd31, 64'hFFFF, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  3'd0, 1'b0, 1'b0};
        tv[6]  = '{1'b1, 5'd31, 64'h1234, 1'b1, 5'd31, 64'h5678, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 5'd0, 64'h0,  3'd0, 1'b0, 1'b0};
        tv[7]  = '{1'b1, 5'd4,  64'h1,    1'b1, 5'd5,  64'h2,    5'd7,  5'd8, 1'b1, 1'b1, 1'b1, 5'd4,  64'h1,  3'd2, 1'b0, 1'b0};
        tv[8]  = '{1'b1, 5'd6,  64'h3,    1'b1, 5'd7,  64'h4,    5'd7,  5'd8, 1'b1, 1'b1, 1'b1, 5'd5,  64'h2,  3'd3, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 5'd9,  64'h5,    1'b1, 5'd10, 64'h6,    5'd7,  5'd8, 1'b1, 1'b0, 1'b1, 5'd6,  64'h3,  3'd3, 1'b1, 1'b0};
        tv[10] = '{1'b1, 5'd11, 64'h7,    1'b1, 5'd12, 64'h8,    5'd7,  5'd8, 1'b1, 1'b0, 1'b1, 5'd7,  64'h4,  3'd3, 1'b1, 1'b0};
        tv[11] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd7,  5'd8, 1'b1, 1'b1, 1'b1, 5'd9,  64'h5,  3'd2, 1'b0, 1'b0};
        tv[12] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd7,  5'd8, 1'b1, 1'b1, 1'b1, 5'd11, 64'h7,  3'd1, 1'b0, 1'b0};
        tv[13] = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    5'd7,  5'd8, 1'b1, 1'b1, 1'b0, 5'd0,  64'h0,  3'd0, 1'b0, 1'b0};
        idle();
        bus.rd_addr1 = 5'd0;
        bus.rd_addr2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset RegWrite", bus.RegWrite, 1'b0);
        chk("reset WriteRegister", bus.WriteRegister, 5'd0);
        chk("reset WriteData", bus.WriteData, 64'd0);
        chk("reset occupancy", bus.occupancy, 3'd0);
        chk("reset hazard1", bus.hazard1, 1'b0);
        #2 reset = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 14; i++) begin
            bus.ld_valid = tv[i].ldv; bus.ld_rd = tv[i].ldrd; bus.ld_data = tv[i].ldd;
            bus.alu_valid = tv[i].alv; bus.alu_rd = tv[i].alrd; bus.alu_data = tv[i].ald;
            bus.rd_addr1 = tv[i].ra1; bus.rd_addr2 = tv[i].ra2;
            #1;
            chk($sformatf("v%0d ld_ready", i), bus.ld_ready, tv[i].e_ldr);
            chk($sformatf("v%0d alu_ready", i), bus.alu_ready, tv[i].e_alr);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d RegWrite", i), bus.RegWrite, tv[i].e_rw);
            chk($sformatf("v%0d WriteRegister", i), bus.WriteRegister, tv[i].e_wr);
            chk($sformatf("v%0d WriteData", i), bus.WriteData, tv[i].e_wd);
            chk($sformatf("v%0d occupancy", i), bus.occupancy, tv[i].e_occ);
            chk($sformatf("v%0d hazard1", i), bus.hazard1, tv[i].e_h1);
            chk($sformatf("v%0d hazard2", i), bus.hazard2, tv[i].e_h2);
        end
        // Wrap: 3*DEPTH writes through both ports against an in-order reference queue.
        sent = 0;
        got = 0;
        for (int c = 0; c < 100 && got < 12; c++) begin
            logic lv, av, el, ea;
            int fr;
            lv = sent < 12 && c % 4 != 3;
            av = (sent + int'(lv)) < 12 && c % 3 != 1;
            bus.ld_valid = lv; bus.ld_rd = 5'(1 + sent % 30); bus.ld_data = 64'hC0DE0000 + 64'(sent);
            bus.alu_valid = av; bus.alu_rd = 5'(1 + (sent + int'(lv)) % 30);
            bus.alu_data = 64'hC0DE0000 + 64'(sent + int'(lv));
            fr = 4 - qr.size();
            el = lv && fr >= 1;
            ea = av && (lv ? fr >= 2 : fr >= 1);
            #1;
            chk("wrap ld_ready", bus.ld_ready, fr >= 1);
            chk("wrap alu_ready", bus.alu_ready, lv ? fr >= 2 : fr >= 1);
            chk("wrap occupancy", bus.occupancy, 64'(qr.size()));
            chk("wrap RegWrite", bus.RegWrite, qr.size() != 0);
            if (qr.size() != 0) begin
                chk("wrap WriteRegister", bus.WriteRegister, qr[0]);
                chk("wrap WriteData", bus.WriteData, qd[0]);
                void'(qr.pop_front());
                void'(qd.pop_front());
                got++;
            end
            if (el) begin
                qr.push_back(bus.ld_rd); qd.push_back(bus.ld_data); sent++;
            end
            if (ea) begin
                qr.push_back(bus.alu_rd); qd.push_back(bus.alu_data); sent++;
            end
            @(posedge clk);
            #1;
        end
        chk("wrap commits", 64'(got), 64'd12);
        // Mid-cycle reset with three entries queued.
        bus.ld_valid = 1'b1; bus.ld_rd = 5'd1; bus.ld_data = 64'h11;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 64'h22;
        @(posedge clk);
        #1;
        bus.ld_rd = 5'd3; bus.ld_data = 64'h33;
        bus.alu_rd = 5'd4; bus.alu_data = 64'h44;
        @(posedge clk);
        #1;
        idle();
        bus.rd_addr1 = 5'd3;
        #1;
        chk("pre-reset occupancy", bus.occupancy, 3'd3);
        chk("pre-reset hazard1", bus.hazard1, 1'b1);
        reset = 1'b1;
        #1;
        chk("async reset RegWrite", bus.RegWrite, 1'b0);
        chk("async reset occupancy", bus.occupancy, 3'd0);
        chk("async reset hazard1", bus.hazard1, 1'b0);
        reset = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("post-reset RegWrite", bus.RegWrite, 1'b0);
            chk("post-reset occupancy", bus.occupancy, 3'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
